// File: rtl/traffic_phase_ctrl.sv
// rtl/traffic_phase_ctrl.sv - N-phase actuated traffic-light controller
// Sequences phases through green/yellow/all-red on a 1 Hz tick, with request-driven skipping and flash mode.
module traffic_phase_ctrl #(
    parameter int CLK_HZ     = 100_000_000,
    parameter int N_PHASES   = 2,
    parameter int MIN_GREEN  = 6,
    parameter int MAX_GREEN  = 9,
    parameter int YELLOW_T   = 2,
    parameter int ALLRED_T   = 2,
    parameter int REST_GREEN = 1,
    parameter int TW         = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [N_PHASES-1:0]         req,
    input  logic                        flash_mode,
    output logic [N_PHASES-1:0]         green,
    output logic [N_PHASES-1:0]         yellow,
    output logic [N_PHASES-1:0]         red,
    output logic [$clog2(N_PHASES)-1:0] active_phase,
    output logic [TW-1:0]               seconds,
    output logic                        tick
);

    localparam int AW = $clog2(N_PHASES);
    localparam int PW = $clog2(CLK_HZ);
    localparam logic [PW-1:0] PS_LAST = PW'(CLK_HZ - 1);
    localparam logic [TW-1:0] T_SAT   = '1;

    typedef enum logic [1:0] {S_GREEN, S_YELLOW, S_ALLRED, S_FLASH} state_t;

    state_t              state, state_nx;
    logic [PW-1:0]       ps_cnt;
    logic [TW-1:0]       timer, timer_nx;
    logic [AW-1:0]       active, active_nx;
    logic                flash_bit, flash_bit_nx;
    logic [N_PHASES-1:0] other;
    logic                any_other;
    logic [AW-1:0]       rr_pick;
    logic [AW-1:0]       cand;
    logic                found;

    assign tick         = (ps_cnt == PS_LAST);
    assign active_phase = active;
    assign seconds      = timer;
    assign any_other    = |other;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ps_cnt <= '0;
        end else if (tick) begin
            ps_cnt <= '0;
        end else begin
            ps_cnt <= ps_cnt + 1'b1;
        end
    end

    // Round-robin search starting after the active phase; the active phase is the last candidate.
    always_comb begin
        other   = '0;
        cand    = '0;
        found   = 1'b0;
        rr_pick = AW'((int'(active) + 1) % N_PHASES);
        for (int i = 0; i < N_PHASES; i++) begin
            other[i] = req[i] && (AW'(i) != active);
        end
        for (int k = 1; k <= N_PHASES; k++) begin
            cand = AW'((int'(active) + k) % N_PHASES);
            if (!found && req[cand]) begin
                rr_pick = cand;
                found   = 1'b1;
            end
        end
    end

    always_comb begin
        state_nx     = state;
        timer_nx     = timer;
        active_nx    = active;
        flash_bit_nx = flash_bit;
        if (tick && timer != T_SAT) begin
            timer_nx = timer + 1'b1;
        end
        case (state)
            S_GREEN: begin
                if (tick && (flash_mode
                             || (timer >= TW'(MIN_GREEN) && any_other)
                             || (timer >= TW'(MAX_GREEN) && (any_other || REST_GREEN == 0)))) begin
                    state_nx = S_YELLOW;
                end
            end
            S_YELLOW: begin
                if (tick && timer >= TW'(YELLOW_T)) begin
                    state_nx = S_ALLRED;
                end
            end
            S_ALLRED: begin
                if (tick && timer >= TW'(ALLRED_T)) begin
                    if (flash_mode) begin
                        state_nx = S_FLASH;
                    end else begin
                        state_nx  = S_GREEN;
                        active_nx = rr_pick;
                    end
                end
            end
            S_FLASH: begin
                if (tick) begin
                    flash_bit_nx = !flash_bit;
                    if (!flash_mode) begin
                        state_nx = S_ALLRED;
                    end
                end
            end
            default: state_nx = S_ALLRED;
        endcase
        if (state_nx != state) begin
            timer_nx = TW'(1);
        end
        if (state_nx == S_FLASH && state != S_FLASH) begin
            flash_bit_nx = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_ALLRED;
            timer     <= TW'(1);
            active    <= AW'(N_PHASES - 1);
            flash_bit <= 1'b1;
        end else begin
            state     <= state_nx;
            timer     <= timer_nx;
            active    <= active_nx;
            flash_bit <= flash_bit_nx;
        end
    end

    always_comb begin
        green  = '0;
        yellow = '0;
        red    = '1;
        for (int i = 0; i < N_PHASES; i++) begin
            case (state)
                S_GREEN: begin
                    green[i] = (AW'(i) == active);
                    red[i]   = (AW'(i) != active);
                end
                S_YELLOW: begin
                    yellow[i] = (AW'(i) == active);
                    red[i]    = (AW'(i) != active);
                end
                S_FLASH: red[i] = flash_bit;
                default: red[i] = 1'b1;
            endcase
        end
    end

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// tb/tb_traffic_phase_ctrl.sv - bench for traffic_phase_ctrl
// Table vectors, hand sequences and a random run against a tick-level reference model.
`timescale 1ns/1ps
module tb_traffic_phase_ctrl;

    localparam int CLK   = 10;
    localparam int MIN_G = 6;
    localparam int MAX_G = 9;
    localparam int YEL   = 2;
    localparam int ARD   = 2;
    localparam int SGRN = 0, SYEL = 1, SARD = 2, SFLS = 3;

    logic       clk = 1'b0;
    logic       reset, flash_mode;
    logic [2:0] req;
    logic [2:0] green, yellow, red;
    logic [1:0] active_phase;
    logic [3:0] seconds;
    logic       tick;

    logic       rst1, fl1;
    logic [2:0] req1;
    logic [2:0] g1, y1, r1;
    logic [1:0] a1;
    logic [3:0] s1;
    logic       t1;

    always #5 clk = ~clk;

    traffic_phase_ctrl #(.CLK_HZ(CLK), .N_PHASES(3)) dut (
        .clk(clk), .reset(reset), .req(req), .flash_mode(flash_mode),
        .green(green), .yellow(yellow), .red(red),
        .active_phase(active_phase), .seconds(seconds), .tick(tick)
    );

    traffic_phase_ctrl #(.CLK_HZ(CLK), .N_PHASES(3), .REST_GREEN(0)) dut_cyc (
        .clk(clk), .reset(rst1), .req(req1), .flash_mode(fl1),
        .green(g1), .yellow(y1), .red(r1),
        .active_phase(a1), .seconds(s1), .tick(t1)
    );

    int n_tests = 0;
    int n_fail  = 0;

    int m_st, m_sec, m_act, m_cnt;
    bit m_fb;

    logic [15:0] dut_full;
    logic [14:0] dut_lamps;
    assign dut_full  = {tick, green, yellow, red, active_phase, seconds};
    assign dut_lamps = {green, yellow, red, active_phase, seconds};

    typedef struct {
        logic       rst;
        logic [2:0] rq;
        logic       fl;
        int         ticks;
        logic [2:0] g, y, r;
        logic [1:0] act;
        logic [3:0] sec;
    } vec_t;
    vec_t tbl[22];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_st = SARD; m_sec = 1; m_act = 2; m_cnt = 0; m_fb = 1'b1;
    endtask

    function automatic int pick(input logic [2:0] r);
        for (int k = 1; k <= 3; k++) begin
            if (r[(m_act + k) % 3]) return (m_act + k) % 3;
        end
        return (m_act + 1) % 3;
    endfunction

    task automatic model_cycle(input logic [2:0] r, input logic f);
        int nst;
        logic [2:0] oth;
        if (m_cnt != CLK - 1) begin
            m_cnt++;
            return;
        end
        m_cnt = 0;
        nst   = m_st;
        oth   = r;
        oth[m_act] = 1'b0;
        case (m_st)
            SGRN: if (f || (m_sec >= MIN_G && oth != 0) || (m_sec >= MAX_G && oth != 0)) nst = SYEL;
            SYEL: if (m_sec >= YEL) nst = SARD;
            SARD: if (m_sec >= ARD) begin
                if (f) nst = SFLS;
                else begin nst = SGRN; m_act = pick(r); end
            end
            default: begin
                m_fb = !m_fb;
                if (!f) nst = SARD;
            end
        endcase
        if (nst != m_st) begin
            m_sec = 1;
            if (nst == SFLS) m_fb = 1'b1;
            m_st = nst;
        end else if (m_sec < 15) begin
            m_sec++;
        end
    endtask

    function automatic logic [15:0] model_out();
        logic [2:0] g, y, r, one;
        g = 3'b000; y = 3'b000; r = 3'b111;
        one = 3'(1 << m_act);
        case (m_st)
            SGRN: begin g = one; r = ~one; end
            SYEL: begin y = one; r = ~one; end
            SFLS: r = m_fb ? 3'b111 : 3'b000;
            default: r = 3'b111;
        endcase
        return {m_cnt == CLK - 1, g, y, r, 2'(m_act), 4'(m_sec)};
    endfunction

    task automatic step_cycle();
        model_cycle(req, flash_mode);
        @(posedge clk);
        @(negedge clk);
        chk("model", 32'(dut_full), 32'(model_out()));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        model_reset();
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Lamp invariants on both instances, every cycle.
    always @(negedge clk) begin
        chk("lamp_invariant",
            32'($onehot0(green | yellow) && (green & yellow) == 0 && (green & red) == 0
                && (yellow & red) == 0 && $onehot0(g1 | y1) && (g1 & y1) == 0
                && (g1 & r1) == 0 && (y1 & r1) == 0),
            32'd1);
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int dur[6];
        logic [11:0] exp1[6];
        reset = 1'b0; rst1 = 1'b0; req = 3'b000; flash_mode = 1'b0;
        req1 = 3'b000; fl1 = 1'b0;
        #1;
        reset = 1'b1; rst1 = 1'b1;

        tbl[0]  = '{1'b1, 3'b000, 1'b0, 0,  3'b000, 3'b000, 3'b111, 2'd2, 4'd1};
        tbl[1]  = '{1'b0, 3'b000, 1'b0, 2,  3'b001, 3'b000, 3'b110, 2'd0, 4'd1};
        tbl[2]  = '{1'b0, 3'b000, 1'b0, 14, 3'b001, 3'b000, 3'b110, 2'd0, 4'd15};
        tbl[3]  = '{1'b0, 3'b000, 1'b0, 6,  3'b001, 3'b000, 3'b110, 2'd0, 4'd15};
        tbl[4]  = '{1'b1, 3'b000, 1'b0, 0,  3'b000, 3'b000, 3'b111, 2'd2, 4'd1};
        tbl[5]  = '{1'b0, 3'b000, 1'b0, 2,  3'b001, 3'b000, 3'b110, 2'd0, 4'd1};
        tbl[6]  = '{1'b0, 3'b100, 1'b0, 5,  3'b001, 3'b000, 3'b110, 2'd0, 4'd6};
        tbl[7]  = '{1'b0, 3'b100, 1'b0, 1,  3'b000, 3'b001, 3'b110, 2'd0, 4'd1};
        tbl[8]  = '{1'b0, 3'b100, 1'b0, 1,  3'b000, 3'b001, 3'b110, 2'd0, 4'd2};
        tbl[9]  = '{1'b0, 3'b100, 1'b0, 1,  3'b000, 3'b000, 3'b111, 2'd0, 4'd1};
        tbl[10] = '{1'b0, 3'b100, 1'b0, 1,  3'b000, 3'b000, 3'b111, 2'd0, 4'd2};
        tbl[11] = '{1'b0, 3'b100, 1'b0, 1,  3'b100, 3'b000, 3'b011, 2'd2, 4'd1};
        tbl[12] = '{1'b0, 3'b100, 1'b0, 2,  3'b100, 3'b000, 3'b011, 2'd2, 4'd3};
        tbl[13] = '{1'b0, 3'b100, 1'b1, 1,  3'b000, 3'b100, 3'b011, 2'd2, 4'd1};
        tbl[14] = '{1'b0, 3'b100, 1'b1, 2,  3'b000, 3'b000, 3'b111, 2'd2, 4'd1};
        tbl[15] = '{1'b0, 3'b100, 1'b1, 1,  3'b000, 3'b000, 3'b111, 2'd2, 4'd2};
        tbl[16] = '{1'b0, 3'b100, 1'b1, 1,  3'b000, 3'b000, 3'b111, 2'd2, 4'd1};
        tbl[17] = '{1'b0, 3'b100, 1'b1, 1,  3'b000, 3'b000, 3'b000, 2'd2, 4'd2};
        tbl[18] = '{1'b0, 3'b100, 1'b1, 1,  3'b000, 3'b000, 3'b111, 2'd2, 4'd3};
        tbl[19] = '{1'b0, 3'b010, 1'b0, 1,  3'b000, 3'b000, 3'b111, 2'd2, 4'd1};
        tbl[20] = '{1'b0, 3'b010, 1'b0, 1,  3'b000, 3'b000, 3'b111, 2'd2, 4'd2};
        tbl[21] = '{1'b0, 3'b010, 1'b0, 1,  3'b010, 3'b000, 3'b101, 2'd1, 4'd1};

        @(negedge clk);
        for (int i = 0; i < 22; i++) begin
            if (tbl[i].rst) do_reset();
            req        = tbl[i].rq;
            flash_mode = tbl[i].fl;
            repeat (tbl[i].ticks * CLK) step_cycle();
            chk($sformatf("vec%0d", i), 32'(dut_lamps),
                32'({tbl[i].g, tbl[i].y, tbl[i].r, tbl[i].act, tbl[i].sec}));
        end

        // Reset asserted in the middle of a yellow interval.
        req = 3'b000; flash_mode = 1'b0;
        do_reset();
        repeat (2 * CLK) step_cycle();
        req = 3'b010;
        repeat (6 * CLK) step_cycle();
        chk("pre_reset_yellow", 32'({yellow, active_phase}), 32'({3'b001, 2'd0}));
        repeat (5) step_cycle();
        #2 reset = 1'b1;
        #1 chk("async_reset", 32'({tick, dut_lamps}),
               32'({1'b0, 3'b000, 3'b000, 3'b111, 2'd2, 4'd1}));
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        req   = 3'b000;
        repeat (2 * CLK) step_cycle();
        chk("recover_green", 32'(dut_lamps), 32'({3'b001, 3'b000, 3'b110, 2'd0, 4'd1}));

        // Random requests and flash toggles against the reference model.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 5) == 0) req = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 299) == 0) flash_mode = !flash_mode;
            step_cycle();
        end

        // Fixed-time cycling with no rest-in-green.
        dur  = '{2, 9, 2, 2, 13, 13};
        exp1 = '{{3'b001, 3'b000, 2'd0, 4'd1}, {3'b000, 3'b001, 2'd0, 4'd1},
                 {3'b000, 3'b000, 2'd0, 4'd1}, {3'b010, 3'b000, 2'd1, 4'd1},
                 {3'b100, 3'b000, 2'd2, 4'd1}, {3'b001, 3'b000, 2'd0, 4'd1}};
        rst1 = 1'b0;
        for (int i = 0; i < 6; i++) begin
            repeat (dur[i] * CLK) @(negedge clk);
            chk($sformatf("cycle%0d", i), 32'({g1, y1, a1, s1}), 32'(exp1[i]));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
